// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared transfer modes, default widths and mode helper for simple_bus agents
package simple_bus_pkg;
   typedef enum logic [1:0] {
      MODE_READ  = 2'b00,
      MODE_WRITE = 2'b01,
      MODE_RSV0  = 2'b10,
      MODE_RSV1  = 2'b11
   } mode_e;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   function automatic logic is_reserved_mode(input logic [1:0] m);
      return m[1];
   endfunction
endpackage

// File: rtl/sb_timeout_ctr.sv
// sb_timeout_ctr: saturating wait counter that flags the last permitted cycle of a TIMEOUT window
module sb_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
   localparam logic [W-1:0] MAX = W'(TIMEOUT);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en && cnt != MAX) cnt <= cnt + W'(1);
   end
   assign expired = cnt >= LAST;
endmodule

// File: rtl/simple_bus_initiator.sv
// simple_bus_initiator: one-command-at-a-time simple_bus master with req/gnt arbitration and rdy timeout
module simple_bus_initiator
   import simple_bus_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [1:0]        cmd_mode,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic              bus_start,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [1:0]        bus_mode,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_rdy
);
   typedef enum logic [2:0] {IDLE, REQ, START, WAIT_RDY, RSP} state_e;
   state_e state, nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] wdata_q;
   logic              expired, active;
   logic              rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_d;
   sb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
      .clk(clk),
      .rst(rst),
      .clr(state != WAIT_RDY),
      .en(state == WAIT_RDY),
      .expired(expired)
   );
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (cmd_valid) nxt = is_reserved_mode(cmd_mode) ? RSP : REQ;
         REQ:      if (bus_gnt) nxt = START;
         START:    nxt = WAIT_RDY;
         WAIT_RDY: if (bus_rdy || expired) nxt = RSP;
         RSP:      if (rsp_ready) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
      active = nxt == START || nxt == WAIT_RDY;
      // only path from IDLE straight to RSP is a reserved mode; rdy in the last counted cycle beats timeout
      rsp_err_d = nxt != RSP ? 1'b0 : state == RSP ? rsp_err : state == IDLE ? 1'b1 : !bus_rdy;
      rsp_rdata_d = nxt != RSP ? '0 : state == RSP ? rsp_rdata :
                    (state == WAIT_RDY && bus_rdy && mode_q == MODE_READ) ? bus_rdata : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         mode_q    <= '0;
         wdata_q   <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         bus_req   <= 1'b0;
         bus_start <= 1'b0;
         bus_addr  <= '0;
         bus_mode  <= '0;
         bus_wdata <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && cmd_valid) begin
            addr_q  <= cmd_addr;
            mode_q  <= cmd_mode;
            wdata_q <= cmd_wdata;
         end
         cmd_ready <= nxt == IDLE;
         rsp_valid <= nxt == RSP;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         bus_req   <= nxt == REQ || active;
         bus_start <= nxt == START;
         bus_addr  <= active ? addr_q : '0;
         bus_mode  <= active ? mode_q : '0;
         bus_wdata <= (active && mode_q == MODE_WRITE) ? wdata_q : '0;
      end
   end
endmodule
